// File: rtl/render_rect_stream.sv
// Filled-rectangle rasteriser streaming clipped pixels over valid/ready in raster order.
// Define RECT_BORDER_EN to build the border classifier; otherwise every pixel is back_color.
module render_rect_stream #(
  parameter int X_BITS     = 9,
  parameter int Y_BITS     = 8,
  parameter int COLOR_BITS = 3,
  parameter int SCREEN_W   = 320,
  parameter int SCREEN_H   = 240,
  parameter int BW_BITS    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [X_BITS-1:0]     origin_x,
  input  logic [Y_BITS-1:0]     origin_y,
  input  logic [X_BITS-1:0]     width,
  input  logic [Y_BITS-1:0]     height,
  input  logic [COLOR_BITS-1:0] back_color,
  input  logic [COLOR_BITS-1:0] border_color,
  input  logic [BW_BITS-1:0]    border_width,
  output logic                  busy,
  output logic                  done,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [X_BITS-1:0]     x_stream,
  output logic [Y_BITS-1:0]     y_stream,
  output logic [COLOR_BITS-1:0] color_stream
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_DONE} state_t;

  localparam logic [X_BITS:0]   SCR_W   = SCREEN_W[X_BITS:0];
  localparam logic [Y_BITS:0]   SCR_H   = SCREEN_H[Y_BITS:0];
  localparam logic [X_BITS:0]   ONE_XW  = {{X_BITS{1'b0}}, 1'b1};
  localparam logic [Y_BITS:0]   ONE_YW  = {{Y_BITS{1'b0}}, 1'b1};
  localparam logic [X_BITS-1:0] ONE_COL = {{(X_BITS-1){1'b0}}, 1'b1};
  localparam logic [Y_BITS-1:0] ONE_ROW = {{(Y_BITS-1){1'b0}}, 1'b1};

  state_t                state;
  logic [X_BITS-1:0]     ox_r, w_r, col, nxt_col;
  logic [Y_BITS-1:0]     oy_r, h_r, row, nxt_row;
  logic [COLOR_BITS-1:0] back_r, nxt_color;
  logic [X_BITS:0]       room_x, eff_w, lim_x;
  logic [Y_BITS:0]       room_y, eff_h, lim_y;
  logic                  col_end, row_end;

  // Clipped extents are evaluated one bit wider so nothing wraps.
  always_comb begin
    room_x = SCR_W - {1'b0, ox_r};
    room_y = SCR_H - {1'b0, oy_r};
    if ({1'b0, ox_r} >= SCR_W)      eff_w = '0;
    else if ({1'b0, w_r} < room_x)  eff_w = {1'b0, w_r};
    else                            eff_w = room_x;
    if ({1'b0, oy_r} >= SCR_H)      eff_h = '0;
    else if ({1'b0, h_r} < room_y)  eff_h = {1'b0, h_r};
    else                            eff_h = room_y;

    col_end = ({1'b0, col} == lim_x);
    row_end = ({1'b0, row} == lim_y);
    if (state == S_LOAD) begin
      nxt_col = '0;
      nxt_row = '0;
    end else if (col_end) begin
      nxt_col = '0;
      nxt_row = row + ONE_ROW;
    end else begin
      nxt_col = col + ONE_COL;
      nxt_row = row;
    end
  end

`ifdef RECT_BORDER_EN
  logic [BW_BITS-1:0]    bw_r;
  logic [COLOR_BITS-1:0] border_r;
  logic [X_BITS:0]       bw_x;
  logic [Y_BITS:0]       bw_y;
  logic                  on_border;

  // Classification uses the unclipped width/height; col+bw >= width avoids a negative width-bw.
  always_comb begin
    bw_x = '0;
    bw_y = '0;
    bw_x[BW_BITS-1:0] = bw_r;
    bw_y[BW_BITS-1:0] = bw_r;
    on_border = ({1'b0, nxt_col} < bw_x) || (({1'b0, nxt_col} + bw_x) >= {1'b0, w_r}) ||
                ({1'b0, nxt_row} < bw_y) || (({1'b0, nxt_row} + bw_y) >= {1'b0, h_r});
    nxt_color = on_border ? border_r : back_r;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bw_r     <= '0;
      border_r <= '0;
    end else if (state == S_IDLE && start) begin
      bw_r     <= border_width;
      border_r <= border_color;
    end
  end
`else
  logic unused_border;
  assign unused_border = ^{border_width, border_color};

  always_comb begin
    nxt_color = back_r;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      pix_valid    <= 1'b0;
      x_stream     <= '0;
      y_stream     <= '0;
      color_stream <= '0;
      col          <= '0;
      row          <= '0;
      ox_r         <= '0;
      oy_r         <= '0;
      w_r          <= '0;
      h_r          <= '0;
      back_r       <= '0;
      lim_x        <= '0;
      lim_y        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ox_r   <= origin_x;
            oy_r   <= origin_y;
            w_r    <= width;
            h_r    <= height;
            back_r <= back_color;
            busy   <= 1'b1;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          lim_x <= eff_w - ONE_XW;
          lim_y <= eff_h - ONE_YW;
          if (eff_w == '0 || eff_h == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            col          <= '0;
            row          <= '0;
            x_stream     <= ox_r;
            y_stream     <= oy_r;
            color_stream <= nxt_color;
            pix_valid    <= 1'b1;
            state        <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (pix_ready) begin
            if (col_end && row_end) begin
              pix_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              col          <= nxt_col;
              row          <= nxt_row;
              x_stream     <= ox_r + nxt_col;
              y_stream     <= oy_r + nxt_row;
              color_stream <= nxt_color;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_render_rect_stream.sv
// Randomised self-checking bench for render_rect_stream against a nested-loop raster model.
module tb_render_rect_stream;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [8:0] origin_x = '0;
  logic [7:0] origin_y = '0;
  logic [8:0] width = '0;
  logic [7:0] height = '0;
  logic [2:0] back_color = '0;
  logic [2:0] border_color = '0;
  logic [2:0] border_width = '0;
  logic       busy, done, pix_valid;
  logic       pix_ready = 1'b0;
  logic [8:0] x_stream;
  logic [7:0] y_stream;
  logic [2:0] color_stream;

  int total = 0;
  int bad = 0;

  typedef struct {int x; int y; int c;} pix_t;
  pix_t exp_q[$];

  render_rect_stream #(
    .X_BITS(9), .Y_BITS(8), .COLOR_BITS(3), .SCREEN_W(320), .SCREEN_H(240), .BW_BITS(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .origin_x(origin_x), .origin_y(origin_y), .width(width), .height(height),
    .back_color(back_color), .border_color(border_color), .border_width(border_width),
    .busy(busy), .done(done), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .x_stream(x_stream), .y_stream(y_stream), .color_stream(color_stream)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Every on-screen pixel of the unclipped rectangle, in raster order.
  task automatic build_model(input int ox, input int oy, input int w, input int h,
                             input int bw, input int bk, input int bc);
    exp_q.delete();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        pix_t p;
        if (ox + c >= 320 || oy + r >= 240) continue;
        p.x = ox + c;
        p.y = oy + r;
`ifdef RECT_BORDER_EN
        p.c = (c < bw || c >= w - bw || r < bw || r >= h - bw) ? bc : bk;
`else
        p.c = bk;
`endif
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic issue_start(input int ox, input int oy, input int w, input int h,
                             input int bw, input int bk, input int bc);
    @(posedge clk); #1;
    origin_x = 9'(ox); origin_y = 8'(oy); width = 9'(w); height = 8'(h);
    border_width = 3'(bw); back_color = 3'(bk); border_color = 3'(bc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    origin_x = 9'($urandom); origin_y = 8'($urandom); width = 9'($urandom);
    height = 8'($urandom); border_width = 3'($urandom);
    back_color = 3'($urandom); border_color = 3'($urandom);
  endtask

  // rmode: 0 = always ready, 1 = alternating, 2 = random
  task automatic run_rect(input string name, input int ox, input int oy, input int w, input int h,
                          input int bw, input int bk, input int bc, input int rmode,
                          input bit mid_start, input bit done_start);
    int n, hs, last_hs_n, first_v, done_n, budget, nexp;
    bit hold_v;
    int hx, hy, hc;
    build_model(ox, oy, w, h, bw, bk, bc);
    nexp = exp_q.size();
    budget = 10 * nexp + 20;
    issue_start(ox, oy, w, h, bw, bk, bc);
    n = 0; hs = 0; last_hs_n = -1; first_v = -1; done_n = -1; hold_v = 0;
    hx = 0; hy = 0; hc = 0;
    while (n <= budget && done_n < 0) begin
      case (rmode)
        0: pix_ready = 1'b1;
        1: pix_ready = n[0];
        default: pix_ready = 1'($urandom);
      endcase
      start = (mid_start && n == 3) || (done_start && n == nexp + 1);
      @(negedge clk);
      if (hold_v) begin
        total++;
        if (pix_valid !== 1'b1 || x_stream !== 9'(hx) || y_stream !== 8'(hy) || color_stream !== 3'(hc)) begin
          bad++;
          $display("FAIL %s stall_hold: got v=%0b (%0d,%0d,%0d) want v=1 (%0d,%0d,%0d)",
                   name, pix_valid, x_stream, y_stream, color_stream, hx, hy, hc);
        end
        hold_v = 0;
      end
      if (pix_valid === 1'b1 && first_v < 0) first_v = n;
      if (pix_valid === 1'b1 && pix_ready) begin
        total++;
        if (hs >= nexp) begin
          bad++;
          $display("FAIL %s extra_pixel: got (%0d,%0d,%0d) want no pixel", name, x_stream, y_stream, color_stream);
        end else if (x_stream !== 9'(exp_q[hs].x) || y_stream !== 8'(exp_q[hs].y) ||
                     color_stream !== 3'(exp_q[hs].c)) begin
          bad++;
          $display("FAIL %s pixel%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", name, hs,
                   x_stream, y_stream, color_stream, exp_q[hs].x, exp_q[hs].y, exp_q[hs].c);
        end
        hs++;
        last_hs_n = n;
      end else if (pix_valid === 1'b1) begin
        hold_v = 1; hx = int'(x_stream); hy = int'(y_stream); hc = int'(color_stream);
      end
      if (done === 1'b1) done_n = n;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    pix_ready = 1'b0;
    total++;
    if (done_n < 0) begin
      bad++;
      $display("FAIL %s done_timeout: got no done within %0d cycles want done", name, budget);
    end
    total++;
    if (hs != nexp) begin
      bad++;
      $display("FAIL %s pixel_count: got %0d want %0d", name, hs, nexp);
    end
    if (done_n >= 0) begin
      total++;
      if (nexp > 0 && done_n != last_hs_n + 1) begin
        bad++;
        $display("FAIL %s done_latency: got cycle %0d want %0d", name, done_n, last_hs_n + 1);
      end else if (nexp == 0 && done_n != 1) begin
        bad++;
        $display("FAIL %s empty_done: got cycle %0d want 1", name, done_n);
      end
    end
    if (nexp == 0) begin
      total++;
      if (first_v != -1) begin
        bad++;
        $display("FAIL %s empty_valid: got valid at cycle %0d want never", name, first_v);
      end
    end else if (rmode == 0) begin
      total++;
      if (first_v != 1 || done_n != nexp + 1) begin
        bad++;
        $display("FAIL %s stream_timing: got first=%0d done=%0d want first=1 done=%0d",
                 name, first_v, done_n, nexp + 1);
      end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || pix_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s after_done: got done=%0b busy=%0b v=%0b want 0 0 0", name, done, busy, pix_valid);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || pix_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: got busy=%0b done=%0b v=%0b want 0 0 0", busy, done, pix_valid);
    end
    total++;
    if (x_stream !== 9'd0 || y_stream !== 8'd0 || color_stream !== 3'd0) begin
      bad++;
      $display("FAIL reset_stream: got (%0d,%0d,%0d) want (0,0,0)", x_stream, y_stream, color_stream);
    end
    reset = 1'b0;
  endtask

  task automatic test_reset_abort;
    int hs, n, events;
    issue_start(50, 60, 4, 4, 1, 2, 6);
    hs = 0; n = 0;
    while (hs < 5 && n < 40) begin
      pix_ready = 1'b1;
      @(negedge clk);
      if (pix_valid === 1'b1) hs++;
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (hs != 5) begin
      bad++;
      $display("FAIL abort_prefix: got %0d pixels want 5", hs);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (pix_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_state: got v=%0b busy=%0b done=%0b want 0 0 0", pix_valid, busy, done);
    end
    events = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pix_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) events++;
    end
    total++;
    if (events != 0) begin
      bad++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", events);
    end
    pix_ready = 1'b0;
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++) begin
      int ox, oy, w, h, bw;
      ox = ($urandom % 3 == 0) ? int'($urandom_range(300, 330)) : int'($urandom_range(0, 319));
      oy = ($urandom % 3 == 0) ? int'($urandom_range(225, 255)) : int'($urandom_range(0, 239));
      w  = int'($urandom_range(0, 24));
      h  = int'($urandom_range(0, 12));
      bw = int'($urandom_range(0, 7));
      run_rect("random", ox, oy, w, h, bw, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               2, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset;
    run_rect("basic", 10, 20, 4, 3, 1, 1, 4, 0, 1'b0, 1'b0);
    run_rect("clip", 318, 238, 5, 4, 1, 2, 5, 0, 1'b0, 1'b0);
    run_rect("backpressure", 100, 100, 3, 1, 0, 3, 6, 1, 1'b0, 1'b0);
    run_rect("zero_width", 10, 10, 0, 5, 1, 3, 6, 0, 1'b0, 1'b0);
    run_rect("offscreen_x", 320, 10, 10, 5, 1, 3, 6, 0, 1'b0, 1'b0);
    run_rect("full_border", 0, 0, 8, 8, 4, 2, 5, 0, 1'b0, 1'b0);
    run_rect("start_ignored", 30, 40, 4, 3, 1, 1, 7, 0, 1'b1, 1'b1);
    test_reset_abort;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
